// File: rtl/p3_axis_forwarder_pkg.sv
// Shared definitions for the p3 AXI-Stream forwarder:
// FSM encoding and width helpers.
package p3_axis_forwarder_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLAIM  = 3'd1,
    S_LEN    = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } fwd_state_e;

  function automatic int fwd_bytes(input int dw);
    return dw / 8;
  endfunction

  // clog2 that never returns 0, so it can size a vector
  function automatic int fwd_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/p3_axis_forwarder_skid_fifo.sv
// Output skid FIFO for the forwarder: power-of-2 depth,
// head word presented combinationally, zero when empty.
module p3_axis_forwarder_skid_fifo
  import p3_axis_forwarder_pkg::*;
#(
  parameter int WIDTH = 73,
  parameter int DEPTH = 4,
  parameter int CNT_W = fwd_w(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PW = fwd_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_wr, do_rd;

  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en &&
                 ((cnt_q != CNT_W'(DEPTH)) || do_rd);

  assign rd_data = empty ? '0 : mem[rp_q];

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (do_wr) wp_d = wp_q + PW'(1);
    if (do_rd) rp_d = rp_q + PW'(1);
    cnt_d = cnt_q + CNT_W'(do_wr) - CNT_W'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/p3_axis_forwarder.sv
// Claims a p3 buffer, reads it over the fwd_* port and
// emits it as AXI4-Stream, then releases it via fwd_done.
module p3_axis_forwarder
  import p3_axis_forwarder_pkg::*;
#(
  parameter int SN_FWD_ADDR_WIDTH = 9,
  parameter int DATA_WIDTH        = 64,
  parameter int PLEN_WIDTH        = 32,
  parameter int RD_LAT            = 1,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy_for_fwd,
  output logic                         rdy_for_fwd_ack,
  input  logic [PLEN_WIDTH-1:0]        fwd_byte_len,
  output logic [SN_FWD_ADDR_WIDTH-1:0] fwd_addr,
  output logic                         fwd_rd_en,
  input  logic [DATA_WIDTH-1:0]        fwd_rd_data,
  output logic                         fwd_done,
  input  logic                         fwd_done_ack,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]      m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [31:0]                  pkt_count
);

  localparam int BYTES = fwd_bytes(DATA_WIDTH);
  localparam int KW    = fwd_w(BYTES);
  localparam int CW    = fwd_w(FIFO_DEPTH) + 1;
  localparam int NW    = SN_FWD_ADDR_WIDTH + 1;
  localparam int LW    = PLEN_WIDTH + 1;
  localparam int FW    = DATA_WIDTH + BYTES + 1;

  localparam logic [LW-1:0] MAXW =
    LW'(2 ** SN_FWD_ADDR_WIDTH);

  fwd_state_e      state_q, state_d;
  logic [NW-1:0]   w_q, w_d;
  logic [NW-1:0]   n_q, n_d;
  logic [KW-1:0]   r_q, r_d;
  logic [CW-1:0]   infl_q, infl_d;
  logic [31:0]     cnt_q, cnt_d;

  logic [RD_LAT-1:0] dv_q, dl_q;
  logic [BYTES-1:0]  dk_q [RD_LAT];

  logic [LW-1:0]    len_ext, words_raw;
  logic             clamp;
  logic             issue, land, pop, w_last;
  logic [BYTES-1:0] keep_i;
  logic [CW:0]      occ;
  logic [CW-1:0]    fifo_cnt;
  logic             fifo_empty;
  logic [FW-1:0]    fifo_in, fifo_out;

  assign len_ext   = {1'b0, fwd_byte_len};
  assign words_raw = (len_ext + LW'(BYTES - 1))
                     / LW'(BYTES);
  assign clamp     = (words_raw > MAXW);

  assign occ   = {1'b0, fifo_cnt} + {1'b0, infl_q};
  assign issue = (state_q == S_STREAM) &&
                 (w_q < n_q) &&
                 (occ < (CW+1)'(FIFO_DEPTH));

  assign w_last = (w_q == n_q - NW'(1));
  assign keep_i = (w_last && r_q != '0) ?
                  ~({BYTES{1'b1}} >> r_q) :
                  {BYTES{1'b1}};

  assign land = dv_q[RD_LAT-1];
  assign pop  = m_axis_tvalid && m_axis_tready;

  assign fifo_in = {fwd_rd_data,
                    dk_q[RD_LAT-1],
                    dl_q[RD_LAT-1]};

  p3_axis_forwarder_skid_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (land),
    .wr_data (fifo_in),
    .rd_en   (pop),
    .rd_data (fifo_out),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_out[FW-1 -: DATA_WIDTH];
  assign m_axis_tkeep  = fifo_out[BYTES:1];
  assign m_axis_tlast  = fifo_out[0];

  assign rdy_for_fwd_ack = (state_q == S_CLAIM);
  assign fwd_done        = (state_q == S_DONE);
  assign fwd_rd_en       = issue;
  assign fwd_addr        = issue ?
                           w_q[SN_FWD_ADDR_WIDTH-1:0] : '0;
  assign pkt_count       = cnt_q;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    n_d     = n_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    infl_d  = infl_q + CW'(issue) - CW'(land);
    unique case (state_q)
      S_IDLE: begin
        if (rdy_for_fwd) state_d = S_CLAIM;
      end
      S_CLAIM: begin
        state_d = S_LEN;
      end
      S_LEN: begin
        w_d = '0;
        n_d = clamp ? NW'(MAXW) : NW'(words_raw);
        // truncated packets end on a full word
        r_d = clamp ? '0 :
              KW'(len_ext % LW'(BYTES));
        state_d = (fwd_byte_len == '0) ?
                  S_DONE : S_STREAM;
      end
      S_STREAM: begin
        if (issue) w_d = w_q + NW'(1);
        if (pop && m_axis_tlast) state_d = S_DONE;
      end
      S_DONE: begin
        if (fwd_done_ack) begin
          cnt_d   = cnt_q + 32'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      n_q     <= '0;
      r_q     <= '0;
      infl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      n_q     <= n_d;
      r_q     <= r_d;
      infl_q  <= infl_d;
      cnt_q   <= cnt_d;
    end
  end

  // beat attributes ride alongside the read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dv_q <= '0;
      dl_q <= '0;
      for (int i = 0; i < RD_LAT; i++) dk_q[i] <= '0;
    end else begin
      dv_q[0] <= issue;
      dl_q[0] <= issue && w_last;
      dk_q[0] <= keep_i;
      for (int i = 1; i < RD_LAT; i++) begin
        dv_q[i] <= dv_q[i-1];
        dl_q[i] <= dl_q[i-1];
        dk_q[i] <= dk_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_p3_axis_forwarder.sv
// Directed bench for p3_axis_forwarder with a p3 fwd-side
// memory model (RD_LAT=1) and a stream sink.
module tb_p3_axis_forwarder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy_for_fwd;
  logic        rdy_for_fwd_ack;
  logic [31:0] fwd_byte_len;
  logic [8:0]  fwd_addr;
  logic        fwd_rd_en;
  logic [63:0] fwd_rd_data;
  logic        fwd_done;
  logic        fwd_done_ack;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic [31:0] pkt_count;

  always #5 clk = ~clk;

  p3_axis_forwarder dut (
    .clk             (clk),
    .rst             (rst),
    .rdy_for_fwd     (rdy_for_fwd),
    .rdy_for_fwd_ack (rdy_for_fwd_ack),
    .fwd_byte_len    (fwd_byte_len),
    .fwd_addr        (fwd_addr),
    .fwd_rd_en       (fwd_rd_en),
    .fwd_rd_data     (fwd_rd_data),
    .fwd_done        (fwd_done),
    .fwd_done_ack    (fwd_done_ack),
    .m_axis_tdata    (tdata),
    .m_axis_tkeep    (tkeep),
    .m_axis_tlast    (tlast),
    .m_axis_tvalid   (tvalid),
    .m_axis_tready   (tready),
    .pkt_count       (pkt_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int a);
    return 8'((a * 7 + 3) ^ (a >> 8));
  endfunction

  logic [63:0] mem [512];

  always @(posedge clk or posedge rst) begin
    if (rst) fwd_rd_data <= '0;
    else if (fwd_rd_en) fwd_rd_data <= mem[fwd_addr];
  end

  int tmode = 0;
  int tcyc  = 0;
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tcyc++;
      if (tmode == 0) tready = 1'b1;
      else if (tcyc >= 10 && tcyc < 30) tready = 1'b0;
      else tready = ((tcyc & 1) == 0);
    end
  end

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t       bq[$];
  int          cyc = 0;
  int          iss = 0;
  int          pops = 0;
  int          ack_cnt = 0;
  int          ack_cyc = 0;
  int          done_cyc = 0;
  bit          done_seen = 0;
  logic        ack_done = 0;
  logic        prev_ack = 0;
  logic        prev_stall = 0;
  logic [63:0] prev_d;
  logic [8:0]  prev_kl;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      iss        = 0;
      pops       = 0;
      prev_ack   = 0;
      prev_stall = 0;
    end else begin
      if (fwd_rd_en) begin
        chk("credit", 64'(iss - pops < 4), 64'd1);
        iss++;
      end
      if (prev_stall) begin
        chk("hold_valid", 64'(tvalid), 64'd1);
        chk("hold_data", tdata, prev_d);
        chk("hold_kl", 64'({tkeep, tlast}),
            64'(prev_kl));
      end
      if (rdy_for_fwd_ack) begin
        chk("ack_width", 64'(prev_ack), 64'd0);
        ack_cnt++;
        ack_cyc  = cyc;
        ack_done = fwd_done;
      end
      prev_ack = rdy_for_fwd_ack;
      if (fwd_done && !done_seen) begin
        done_seen = 1;
        done_cyc  = cyc;
      end
      if (tvalid && tready) begin
        bq.push_back('{d: tdata, k: tkeep, l: tlast});
        pops++;
      end
      prev_stall = tvalid && !tready;
      prev_d     = tdata;
      prev_kl    = {tkeep, tlast};
    end
  end

  int exp_pkts = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pkt(input int len,
                         input int nb,
                         input logic [7:0] lk,
                         input int ack_dly,
                         input bit hold);
    int a0;
    logic [7:0]  ek;
    logic [63:0] ed, m;
    a0 = ack_cnt;
    bq.delete();
    done_seen    = 0;
    fwd_byte_len = 32'(len);
    rdy_for_fwd  = 1'b1;
    for (int n = 0; n < 400 && ack_cnt == a0; n++)
      tick();
    chk("claim", 64'(ack_cnt - a0), 64'd1);
    chk("claim_done_low", 64'(ack_done), 64'd0);
    if (!hold) rdy_for_fwd = 1'b0;
    for (int n = 0; n < 3000 && !done_seen; n++)
      tick();
    chk("done_seen", 64'(done_seen), 64'd1);
    if (len == 0)
      chk("zero_len_latency",
          64'(done_cyc - ack_cyc), 64'd2);
    repeat (ack_dly) tick();
    chk("done_held", 64'(fwd_done), 64'd1);
    fwd_done_ack = 1'b1;
    tick();
    fwd_done_ack = 1'b0;
    chk("done_drop", 64'(fwd_done), 64'd0);
    exp_pkts++;
    chk("pkt_count", 64'(pkt_count), 64'(exp_pkts));
    chk("beats", 64'(bq.size()), 64'(nb));
    for (int i = 0; i < bq.size() && i < nb; i++) begin
      ek = (i == nb - 1) ? lk : 8'hFF;
      m  = '0;
      for (int b = 0; b < 8; b++) begin
        ed[63 - 8*b -: 8] = pat(i * 8 + b);
        if (ek[7 - b]) m[63 - 8*b -: 8] = 8'hFF;
      end
      chk("beat_data", bq[i].d & m, ed & m);
      chk("beat_keep", 64'(bq[i].k), 64'(ek));
      chk("beat_last", 64'(bq[i].l), 64'(i == nb - 1));
    end
  endtask

  task automatic chk_reset_outs();
    chk("rst_ctrl",
        64'({rdy_for_fwd_ack, fwd_rd_en, fwd_addr,
             fwd_done, tvalid, tkeep, tlast}), 64'd0);
    chk("rst_tdata", tdata, 64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
  endtask

  typedef struct {
    int         len;
    int         mode;
    int         beats;
    logic [7:0] lk;
  } vec_t;

  vec_t vt[9];
  int   base;
  logic [31:0] pc0;

  initial begin
    vt[0] = '{len: 64,   mode: 0, beats: 8,   lk: 8'hFF};
    vt[1] = '{len: 13,   mode: 0, beats: 2,   lk: 8'hF8};
    vt[2] = '{len: 0,    mode: 0, beats: 0,   lk: 8'hFF};
    vt[3] = '{len: 100,  mode: 1, beats: 13,  lk: 8'hF0};
    vt[4] = '{len: 1,    mode: 0, beats: 1,   lk: 8'h80};
    vt[5] = '{len: 7,    mode: 0, beats: 1,   lk: 8'hFE};
    vt[6] = '{len: 4095, mode: 0, beats: 512, lk: 8'hFE};
    vt[7] = '{len: 4100, mode: 0, beats: 512, lk: 8'hFF};
    vt[8] = '{len: 37,   mode: 1, beats: 5,   lk: 8'hF8};

    for (int w = 0; w < 512; w++)
      for (int b = 0; b < 8; b++)
        mem[w][63 - 8*b -: 8] = pat(w * 8 + b);

    rst          = 1'b1;
    rdy_for_fwd  = 1'b0;
    fwd_byte_len = '0;
    fwd_done_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 9; i++) begin
      tmode = vt[i].mode;
      tcyc  = 0;
      run_pkt(vt[i].len, vt[i].beats, vt[i].lk, 1, 0);
      tmode = 0;
      repeat (2) tick();
    end

    // stray ack while idle must not count
    pc0 = pkt_count;
    fwd_done_ack = 1'b1;
    tick();
    fwd_done_ack = 1'b0;
    tick();
    chk("stray_ack", 64'(pkt_count), 64'(pc0));

    base = ack_cnt;
    run_pkt(24, 3, 8'hFF, 5, 1);
    run_pkt(13, 2, 8'hF8, 5, 0);
    repeat (6) tick();
    chk("acks_b2b", 64'(ack_cnt - base), 64'd2);

    base = ack_cnt;
    fwd_byte_len = 32'd200;
    rdy_for_fwd  = 1'b1;
    for (int n = 0; n < 50 && ack_cnt == base; n++)
      tick();
    rdy_for_fwd = 1'b0;
    for (int n = 0; n < 50 && pops < 3; n++) tick();
    chk("mid_stream", 64'(pops >= 3), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs();
    exp_pkts = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) tick();
    run_pkt(8, 1, 8'hFF, 0, 0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
